// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame layout constants and receiver state encoding
package ps2_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, DPS = 2'b01, LOAD = 2'b10} state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;
  localparam int START_IDX      = 0;
  localparam int PAR_IDX        = 9;
  localparam int STOP_IDX       = 10;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: ps2c debounce, level changes only after FILTER_LEN identical samples; emits fall_edge tick
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2c,
  output logic fall_edge
);
  logic [FILTER_LEN-1:0] sr;
  logic f, f_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sr <= '1;
      f  <= 1'b1;
    end else begin
      sr <= {ps2c, sr[FILTER_LEN-1:1]};
      f  <= f_next;
    end
  always_comb f_next = (&sr) ? 1'b1 : (~|sr) ? 1'b0 : f;
  assign fall_edge = f & ~f_next;
endmodule

// File: rtl/ps2_rx_chk.sv
// ps2_rx_chk: PS/2 device-to-host receiver with parity/framing checks and idle indication
// Optional watchdog abort of stalled frames: define PS2_RX_TIMEOUT_EN
module ps2_rx_chk
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_idle,
  output logic       timeout_tick
);
  state_t state, state_next;
  logic [3:0] n, n_next;
  logic [PS2_FRAME_BITS-1:0] b, b_next;
  logic vld, fall_edge, wd_hit;
  if (FILTER_LEN < 2 || FILTER_LEN > 32 || TIMEOUT_CYCLES < 16) begin : g_bad_cfg
    $error("ps2_rx_chk: illegal FILTER_LEN or TIMEOUT_CYCLES");
  end
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk), .reset_n(reset_n), .ps2c(ps2c), .fall_edge(fall_edge)
  );
`ifdef PS2_RX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  logic [WW-1:0] wd;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wd <= '0;
    else wd <= (fall_edge || state != DPS) ? '0 : wd + 1'b1;
  // a coinciding fall_edge keeps the frame alive
  assign wd_hit = (state == DPS) && !fall_edge && (wd == WW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      n     <= '0;
      b     <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_next;
      n     <= n_next;
      b     <= b_next;
      vld   <= vld | (state == LOAD);
    end
  always_comb begin
    state_next = state;
    n_next     = n;
    b_next     = b;
    case (state)
      IDLE: if (fall_edge && rx_en) begin
        b_next     = {ps2d, b[PS2_FRAME_BITS-1:1]};
        n_next     = 4'd9;
        state_next = DPS;
      end
      DPS: if (fall_edge) begin
        b_next     = {ps2d, b[PS2_FRAME_BITS-1:1]};
        n_next     = (n == 4'd0) ? n : n - 4'd1;
        state_next = (n == 4'd0) ? LOAD : DPS;
      end else if (wd_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // flags stay quiet until a first frame has completed since reset
  assign rx_done_tick = (state == LOAD);
  assign rx_idle      = (state == IDLE);
  assign timeout_tick = wd_hit;
  assign dout         = b[PS2_DATA_BITS:1];
  assign parity_err   = vld & ~^b[PAR_IDX:1];
  assign frame_err    = vld & (b[START_IDX] | ~b[STOP_IDX]);
endmodule

// File: tb/tb_ps2_rx_chk.sv
// tb_ps2_rx_chk: directed and randomized PS/2 frames checked against a frame-level reference model
module tb_ps2_rx_chk;
  localparam int L = 8, TO = 200, HALF = 16;
  logic clk = 0, reset_n = 0, ps2c = 1, ps2d = 1, rx_en = 0;
  logic rx_done_tick, parity_err, frame_err, rx_idle, timeout_tick;
  logic [7:0] dout;
  int checks = 0, errors = 0, done_cnt = 0, to_cnt = 0, idle_viol = 0;
  bit watch_idle = 0;
  always #5 clk = ~clk;
  ps2_rx_chk #(.FILTER_LEN(L), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rx_done_tick(rx_done_tick), .dout(dout), .parity_err(parity_err),
    .frame_err(frame_err), .rx_idle(rx_idle), .timeout_tick(timeout_tick)
  );
  always @(posedge clk) begin
    if (rx_done_tick) done_cnt++;
    if (timeout_tick) to_cnt++;
  end
  always @(negedge clk) if (watch_idle && !rx_idle) idle_viol++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic logic [10:0] mk(input logic [7:0] d, input bit par_ok, input bit stop, input bit start = 0);
    logic p;
    p = (($countones(d) % 2) == 0) ^ !par_ok;
    return {stop, p, d, start};
  endfunction
  task automatic send_frame(input string tag, input logic [10:0] b, input bit exp_rx, input int nbits = 11);
    int d0, at;
    d0 = done_cnt;
    at = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2d = b[i];
      repeat (HALF) @(negedge clk);
      ps2c = 0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (rx_done_tick && at == 0) at = k;
      end
      ps2c = 1;
    end
    repeat (HALF) @(negedge clk);
    if (nbits == 11) begin
      chk({tag, " latency"}, at, exp_rx ? L + 1 : 0);
      chk({tag, " pulses"}, done_cnt - d0, exp_rx ? 1 : 0);
      if (exp_rx) begin
        chk({tag, " dout"}, dout, b[8:1]);
        chk({tag, " parity_err"}, parity_err, ($countones(b[9:1]) % 2) == 0);
        chk({tag, " frame_err"}, frame_err, b[0] | !b[10]);
      end
    end
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, " rx_idle"}, rx_idle, 1);
    chk({tag, " dout"}, dout, 0);
    chk({tag, " parity_err"}, parity_err, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " rx_done_tick"}, rx_done_tick, 0);
    chk({tag, " timeout_tick"}, timeout_tick, 0);
  endtask
  initial begin
    int d0;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) reset_n = 1;
    rx_en = 1;
    repeat (4) @(negedge clk);
    send_frame("f1c", mk(8'h1C, 1, 1), 1);
    send_frame("f1c_badpar", mk(8'h1C, 0, 1), 1);
    send_frame("ff0_badstop", mk(8'hF0, 1, 0), 1);
    watch_idle = 1;
    d0 = done_cnt;
    ps2c = 0;
    repeat (L - 1) @(negedge clk);
    ps2c = 1;
    repeat (3 * L) @(negedge clk);
    chk("glitch idle", idle_viol, 0);
    chk("glitch pulses", done_cnt - d0, 0);
    rx_en = 0;
    send_frame("f5a_disabled", mk(8'h5A, 1, 1), 0);
    chk("disabled idle", idle_viol, 0);
    watch_idle = 0;
    rx_en = 1;
    send_frame("f5a", mk(8'h5A, 1, 1), 1);
    for (int r = 0; r < 8; r++) begin
      d = 8'($urandom);
      send_frame($sformatf("rand%0d", r),
                 mk(d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0), 1);
    end
    send_frame("stall", mk(8'hE3, 1, 1), 1, 5);
    d0 = done_cnt;
    repeat (TO + 40) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    chk("timeout pulses", to_cnt, 1);
    chk("timeout idle", rx_idle, 1);
    chk("timeout no done", done_cnt - d0, 0);
    send_frame("ff0_after_to", mk(8'hF0, 1, 1), 1);
    send_frame("partial", mk(8'hA5, 0, 0), 1, 3);
`else
    chk("stall no timeout", to_cnt, 0);
    chk("stall waits", rx_idle, 0);
    chk("stall no done", done_cnt - d0, 0);
`endif
    d0 = done_cnt;
    @(negedge clk) reset_n = 0;
    #1 check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (4 * HALF) @(negedge clk);
    chk("midreset no done", done_cnt - d0, 0);
    chk("midreset idle", rx_idle, 1);
    send_frame("final", mk(8'($urandom), 1, 1), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
